seq_scaled_addsub: RTL and testbench
====================================

Name: seq_scaled_addsub

Overview:
Parametrised multi-cycle arithmetic unit that computes B + K*A or B - K*A on unsigned operands, with an unsigned overflow/underflow flag. It generalises the fixed B - 2A datapath to any WIDTH and any multiplier K of K_W bits. K*A is formed by sequential shift-and-add, one multiplier bit per cycle. Operands enter and results leave through valid/ready handshakes, so the unit drops between operand producers and result consumers in the datapath.

Parameters:
WIDTH, 16, operand and result width in bits (>=2)
K_W, 4, multiplier width in bits (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set valid
in_ready  output  1  unit can accept operands
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
k  input  K_W  multiplier K, unsigned
sub  input  1  1: B - K*A; 0: B + K*A
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  (B ± K*A) mod 2^WIDTH
flag  output  1  1 if the exact result is outside [0, 2^WIDTH-1]

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0, result=0, flag=0, internal registers cleared.
  - in_ready=1 once rst_n is released; it is 0 while rst_n=0.
- States: IDLE, MUL, FIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture a, b, k, sub; clear the product accumulator P (WIDTH+K_W bits); go to MUL.
- MUL:
  - Each cycle, if the current LSB of the multiplier shift register is 1, P += A shifted left by the bit index.
  - Then shift the multiplier right one bit.
  - After exactly K_W MUL cycles, go to FIN.
- FIN:
  - One cycle. Compute T = B ± P at WIDTH+K_W+1 bits, signed.
  - Register result = T[WIDTH-1:0].
  - Register flag = 1 if T<0 or T>=2^WIDTH.
  - Go to DONE.
- DONE:
  - out_valid=1; result and flag are held stable.
  - On out_ready, go to IDLE. out_valid drops and in_ready rises on the next cycle.
- No overlap: in_ready=0 in MUL, FIN and DONE; new operands are never accepted while a result is pending.
- Latency: out_valid rises K_W+1 cycles after the accept edge (5 for K_W=4). Throughput is one operation per K_W+3 cycles when out_ready is held high.
- Inputs a, b, k and sub may change freely after the accept edge without affecting the operation.
- Arithmetic: all operands unsigned. P cannot overflow its WIDTH+K_W bits. The flag covers both add overflow and subtract borrow.
- Reset mid-operation: any state aborts to IDLE. No out_valid is produced for the aborted operation.
- out_ready asserted outside DONE is ignored.

Optional Feature:
- Macro: SEQ_SCALED_ADDSUB_EARLY_EXIT_EN.
- Defined: MUL leaves for FIN as soon as the shifted multiplier is zero after the current step. MUL cycles = max(1, msb_index(k)+1); latency = MUL cycles + 1. k=0 gives latency 2; k=2 gives latency 3.
- Undefined: fixed latency K_W+1 for every k. Result and flag are identical either way.

Decomposition:
- Shared package seq_arith_pkg:
  - state enum (IDLE, MUL, FIN, DONE);
  - localparam helpers for the P width (WIDTH+K_W) and the T width (WIDTH+K_W+1).
- One sub-module, addsub_n (parameter N): ripple add/subtract, N-bit, using the XOR-invert-B plus carry-in scheme; outputs sum and carry-out.
- addsub_n is instantiated twice:
  - in MUL, as the accumulator adder;
  - in FIN, as the final add/subtract.

Test Plan (WIDTH=16, K_W=4, macro undefined unless stated):
1. a=3, b=100, k=2, sub=1 -> result=94, flag=0; out_valid exactly 5 cycles after the accept edge.
2. a=0x1000, b=0, k=15, sub=0 -> result=0xF000, flag=0. Then a=0x2000, k=8 -> result=0x0000, flag=1.
3. a=5, b=4, k=1, sub=1 -> result=0xFFFF, flag=1. Then a=0, b=0x1234, k=9, sub=1 -> result=0x1234, flag=0.
4. Hold out_ready=0 for 3 cycles in DONE -> out_valid, result and flag stable; in_ready=0 and a concurrent in_valid is ignored. Raise out_ready -> in_ready=1 on the next cycle.
5. Pulse rst_n=0 during the 2nd MUL cycle -> out_valid=0, result=0, flag=0 immediately. After release, in_ready=1 and no stale out_valid appears; a new operation completes correctly.
6. With the macro defined: k=0, b=7 -> result=7, flag=0, latency 2. Then k=2, a=3, b=100, sub=1 -> result=94, latency 3.

Source files
------------

// File: rtl/seq_arith_pkg.sv
// Shared types and width helpers for the sequential scaled add/subtract unit.
package seq_arith_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StFin,
    StDone
  } state_e;

  // Product accumulator width: WIDTH x K_W unsigned product never exceeds this.
  function automatic int unsigned p_width(input int unsigned width, input int unsigned k_w);
    return width + k_w;
  endfunction

  // Final add/subtract width: one extra bit so B - P is representable as signed.
  function automatic int unsigned t_width(input int unsigned width, input int unsigned k_w);
    return width + k_w + 1;
  endfunction

endpackage

// File: rtl/addsub_n.sv
// N-bit ripple adder/subtractor: sum = a + (b ^ {N{sub}}) + sub, with carry-out.
module addsub_n #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] b_x;
  logic [N:0]   carry;

  assign b_x = b ^ {N{sub}};

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = sub;
    for (int i = 0; i < N; i++) begin
      sum[i]       = a[i] ^ b_x[i] ^ carry[i];
      carry[i+1]   = (a[i] & b_x[i]) | (carry[i] & (a[i] ^ b_x[i]));
    end
    cout = carry[N];
  end

endmodule

// File: rtl/seq_scaled_addsub.sv
// Multi-cycle B +/- K*A with overflow/borrow flag and valid/ready handshakes.
// Define SEQ_SCALED_ADDSUB_EARLY_EXIT_EN to end the multiply once the multiplier is exhausted.
module seq_scaled_addsub
  import seq_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned K_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [K_W-1:0]   k,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag
);

  localparam int unsigned PW = p_width(WIDTH, K_W);
  localparam int unsigned TW = t_width(WIDTH, K_W);

  state_e           state_q, state_d;
  logic [PW-1:0]    a_sh_q, a_sh_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [K_W-1:0]   m_q, m_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_q, flag_d;

`ifndef SEQ_SCALED_ADDSUB_EARLY_EXIT_EN
  localparam int unsigned CW = $clog2(K_W + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  logic [PW-1:0] mul_sum;
  logic          unused_mul_cout;
  logic [TW-1:0] fin_sum;
  logic          fin_cout;
  logic          mul_last;

  addsub_n #(
    .N(PW)
  ) u_mul_add (
    .a   (p_q),
    .b   (a_sh_q),
    .sub (1'b0),
    .sum (mul_sum),
    .cout(unused_mul_cout)
  );

  addsub_n #(
    .N(TW)
  ) u_fin_addsub (
    .a   ({{(TW - WIDTH){1'b0}}, b_q}),
    .b   ({1'b0, p_q}),
    .sub (sub_q),
    .sum (fin_sum),
    .cout(fin_cout)
  );

`ifdef SEQ_SCALED_ADDSUB_EARLY_EXIT_EN
  assign mul_last = (m_q >> 1) == '0;
`else
  assign mul_last = cnt_q == CW'(K_W - 1);
`endif

  assign in_ready  = rst_n && (state_q == StIdle);
  assign out_valid = state_q == StDone;
  assign result    = result_q;
  assign flag      = flag_q;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    p_d      = p_q;
    b_d      = b_q;
    m_d      = m_q;
    sub_d    = sub_q;
    result_d = result_q;
    flag_d   = flag_q;
`ifndef SEQ_SCALED_ADDSUB_EARLY_EXIT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          a_sh_d  = PW'(a);
          b_d     = b;
          m_d     = k;
          sub_d   = sub;
          p_d     = '0;
`ifndef SEQ_SCALED_ADDSUB_EARLY_EXIT_EN
          cnt_d   = '0;
`endif
          state_d = StMul;
        end
      end
      StMul: begin
        if (m_q[0]) p_d = mul_sum;
        a_sh_d = a_sh_q << 1;
        m_d    = m_q >> 1;
`ifndef SEQ_SCALED_ADDSUB_EARLY_EXIT_EN
        cnt_d  = cnt_q + 1'b1;
`endif
        if (mul_last) state_d = StFin;
      end
      StFin: begin
        result_d = fin_sum[WIDTH-1:0];
        // Upper bits catch add overflow and negative results; carry-out vs sub catches borrow.
        flag_d   = (|fin_sum[TW-1:WIDTH]) | (fin_cout ^ sub_q);
        state_d  = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      p_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      flag_q   <= 1'b0;
`ifndef SEQ_SCALED_ADDSUB_EARLY_EXIT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      p_q      <= p_d;
      b_q      <= b_d;
      m_q      <= m_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      flag_q   <= flag_d;
`ifndef SEQ_SCALED_ADDSUB_EARLY_EXIT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_scaled_addsub.sv
// Bench for seq_scaled_addsub: arithmetic reference model plus directed vectors with literal results.
module tb_seq_scaled_addsub;

  localparam int unsigned W  = 16;
  localparam int unsigned KW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [KW-1:0] k;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          flag;

  int total = 0;
  int bad   = 0;
  int edges = 0;

  seq_scaled_addsub #(
    .WIDTH(W),
    .K_W  (KW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .k        (k),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flag     (flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] res;
    bit           flg;
    int           lat;
    int           acc;
  } exp_t;

  // Reference: exact integer arithmetic, then wrap and range-test.
  function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                 input logic [KW-1:0] ki, input logic si);
    exp_t   e;
    longint t;
    longint prod;
    int     msb;
    prod  = longint'(ki) * longint'(ai);
    t     = si ? longint'(bi) - prod : longint'(bi) + prod;
    e.res = t[W-1:0];
    e.flg = (t < 0) || (t >= (longint'(1) << W));
    msb = 0;
    for (int i = 0; i < int'(KW); i++) if (ki[i]) msb = i + 1;
`ifdef SEQ_SCALED_ADDSUB_EARLY_EXIT_EN
    e.lat = ((msb < 1) ? 1 : msb) + 1;
`else
    e.lat = msb * 0 + int'(KW) + 1;
`endif
    e.acc = 0;
    return e;
  endfunction

  // Compare process: every falling edge, DUT outputs against the model queue.
  exp_t exp_q[$];
  bit   busy    = 1'b0;
  bit   pending = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_flag", 64'(flag), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        exp_q.delete();
        busy    = 1'b0;
        pending = 1'b0;
      end else begin
        check("in_ready", 64'(in_ready), 64'(!busy));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", 64'(out_valid), 64'(0));
          end else begin
            if (!pending) check("latency", 64'(edges - exp_q[0].acc), 64'(exp_q[0].lat));
            pending = 1'b1;
            check("result", 64'(result), 64'(exp_q[0].res));
            check("flag", 64'(flag), 64'(exp_q[0].flg));
          end
        end else if (pending) begin
          check("valid_held", 64'(out_valid), 64'(1));
        end else if (busy && exp_q.size() > 0 && (edges - exp_q[0].acc) > 40) begin
          check("valid_timeout", 64'(out_valid), 64'(1));
          void'(exp_q.pop_front());
          busy = 1'b0;
        end
        if (in_valid && in_ready) begin
          exp_t e;
          e     = model(a, b, k, sub);
          e.acc = edges + 1;
          exp_q.push_back(e);
          busy = 1'b1;
        end
        if (out_valid && out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          pending = 1'b0;
          busy    = 1'b0;
        end
      end
    end
  end

  task automatic accept_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                           input logic [KW-1:0] ki, input logic si);
    int n = 0;
    a = ai; b = bi; k = ki; sub = si;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept", 64'(in_ready), 64'(1));
    if (!in_ready) $fatal(1, "operand never accepted");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a   = 16'($urandom);
    b   = 16'($urandom);
    k   = 4'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic finish_op(input logic [W-1:0] res, input bit flg, input int lat,
                           input int hold);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!out_valid && n < 30);
    check("lat_lit", 64'(n), 64'(lat));
    check("res_lit", 64'(result), 64'(res));
    check("flag_lit", 64'(flag), 64'(flg));
    repeat (hold) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ready_after_done", 64'(in_ready), 64'(1));
    check("valid_dropped", 64'(out_valid), 64'(0));
  endtask

  task automatic do_vec(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic [KW-1:0] ki,
                        input logic si, input logic [W-1:0] res, input bit flg,
                        input int lat_fixed, input int lat_early, input int hold);
    int lat;
`ifdef SEQ_SCALED_ADDSUB_EARLY_EXIT_EN
    lat = lat_early + lat_fixed * 0;
`else
    lat = lat_fixed + lat_early * 0;
`endif
    @(posedge clk);
    #1;
    out_ready = (hold == 0);
    accept_op(ai, bi, ki, si);
    finish_op(res, flg, lat, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; k = '0; sub = 1'b0;
    #2;
    check("init_in_ready", 64'(in_ready), 64'(0));
    check("init_out_valid", 64'(out_valid), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    //     a        b        k      sub   result   flag lat lat_ee hold
    do_vec(16'd3,    16'd100, 4'd2,  1'b1, 16'd94,   1'b0, 5, 3, 0);
    do_vec(16'h1000, 16'h0,   4'd15, 1'b0, 16'hF000, 1'b0, 5, 5, 0);
    do_vec(16'h2000, 16'h0,   4'd8,  1'b0, 16'h0000, 1'b1, 5, 5, 0);
    do_vec(16'd5,    16'd4,   4'd1,  1'b1, 16'hFFFF, 1'b1, 5, 2, 0);
    do_vec(16'd0,    16'h1234, 4'd9, 1'b1, 16'h1234, 1'b0, 5, 5, 0);
    do_vec(16'h1000, 16'hF000, 4'd15, 1'b1, 16'h0000, 1'b0, 5, 5, 0);
    // Consumer stalls three cycles with a competing operand offered.
    do_vec(16'd7,    16'd10,  4'd3,  1'b0, 16'd31,   1'b0, 5, 3, 3);

    // Reset during the second multiply cycle aborts the operation.
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    accept_op(16'd1, 16'd2, 4'd15, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_result", 64'(result), 64'(0));
    check("abort_flag", 64'(flag), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    repeat (8) @(negedge clk);
    check("no_stale_valid", 64'(out_valid), 64'(0));
    do_vec(16'hFFFF, 16'hFFFF, 4'd15, 1'b0, 16'hFFF0, 1'b1, 5, 5, 0);

`ifdef SEQ_SCALED_ADDSUB_EARLY_EXIT_EN
    do_vec(16'h55,   16'd7,   4'd0,  1'b0, 16'd7,    1'b0, 5, 2, 0);
    do_vec(16'd3,    16'd100, 4'd2,  1'b1, 16'd94,   1'b0, 5, 3, 0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
